// File: rtl/mmio_mailbox_fifo.sv
// Purpose : MMIO responder exposing a 32-bit word FIFO mailbox (DATA/STATUS/CTRL/PEEK).
// Latency : read data registered, valid the cycle after the cs edge; idle cycles drive 0.
// Backpres: none; push to a full FIFO drops the word (ovf), pop from empty returns 0 (unf).
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high; wins over a same-cycle access
//   cs         access strobe for this cycle
//   adr[1:0]   register select: 0 DATA, 1 STATUS, 2 CTRL, 3 PEEK
//   wren[3:0]  byte write enables, 0 = read
//   di         write data
//   dout       registered read data, ORed onto the bus (the bus-level "do" signal)
//   not_empty  FIFO holds at least one word
//   count      current occupancy, zero-extended to 8 bits
module mmio_mailbox_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic [1:0]       adr,
    input  logic [3:0]       wren,
    input  logic [WIDTH-1:0] di,
    output logic [WIDTH-1:0] dout,
    output logic             not_empty,
    output logic [7:0]       count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;   // pointer width incl. wrap bit

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_PEEK   = 2'd3;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         occ;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  empty;
    logic                  full;
    logic                  ovf;
    logic                  unf;
    logic                  perr;

    logic                  rd_acc;
    logic                  wr_acc;
    logic                  push_ok;
    logic                  push_drop;
    logic                  push_part;
    logic                  pop_ok;
    logic                  pop_unf;
    logic                  do_flush;
    logic                  do_clear;
    logic [WIDTH-1:0]      head;
    logic [31:0]           status;
    logic [WIDTH-1:0]      rd_val;

    assign wr_addr = wr_ptr[DEPTH_LOG2-1:0];
    assign rd_addr = rd_ptr[DEPTH_LOG2-1:0];

    // Same address with different wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_addr == rd_addr) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

    // Modular difference stays correct across pointer wrap.
    assign occ       = wr_ptr - rd_ptr;
    assign count     = 8'(occ);
    assign not_empty = !empty;

    // Access decode; only one access can exist per cycle.
    assign rd_acc    = cs && (wren == 4'h0);
    assign wr_acc    = cs && (wren != 4'h0);
    assign push_ok   = wr_acc && (adr == REG_DATA) && (wren == 4'hF) && !full;
    assign push_drop = wr_acc && (adr == REG_DATA) && (wren == 4'hF) && full;
    assign push_part = wr_acc && (adr == REG_DATA) && (wren != 4'hF);
    assign pop_ok    = rd_acc && (adr == REG_DATA) && !empty;
    assign pop_unf   = rd_acc && (adr == REG_DATA) && empty;
    assign do_flush  = wr_acc && (adr == REG_CTRL) && di[0];
    assign do_clear  = wr_acc && (adr == REG_CTRL) && di[1];

    // Head is read asynchronously so pop/peek data lands in dout on the access edge.
    assign head = mem[rd_addr];

    // STATUS reflects state before this cycle's side effects.
    assign status = {16'h0000, count, 3'b000, perr, unf, ovf, full, empty};

    always_comb begin
        rd_val = '0;
        case (adr)
            REG_DATA:   rd_val = empty ? '0 : head;
            REG_STATUS: rd_val = WIDTH'(status);
            REG_CTRL:   rd_val = '0;
            REG_PEEK:   rd_val = empty ? '0 : head;
            default:    rd_val = '0;
        endcase
    end

    // Storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_addr] <= di;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            perr   <= 1'b0;
            dout   <= '0;
        end else begin
            // dout is zero on every edge that is not a read so the OR-bus stays clean.
            dout <= rd_acc ? rd_val : '0;

            if (do_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (do_clear) begin
                ovf  <= 1'b0;
                unf  <= 1'b0;
                perr <= 1'b0;
            end else begin
                if (push_drop) ovf  <= 1'b1;
                if (pop_unf)   unf  <= 1'b1;
                if (push_part) perr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmio_mailbox_fifo.sv
// Purpose : self-checking bench for mmio_mailbox_fifo using a reference model and read scoreboard.
// Latency : expected read data is queued at drive time and compared one edge later.
// Backpres: n/a (bench drives one access per cycle or idles).
module tb_mmio_mailbox_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [1:0]  adr;
    logic [3:0]  wren;
    logic [31:0] di;
    logic [31:0] dout;
    logic        not_empty;
    logic [7:0]  count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] model_q[$];
    logic        m_ovf;
    logic        m_unf;
    logic        m_perr;

    // Expected dout values for issued reads, in issue order
    logic [31:0] sb_q[$];

    mmio_mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .adr       (adr),
        .wren      (wren),
        .di        (di),
        .dout      (dout),
        .not_empty (not_empty),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compares dout after every edge: popped scoreboard value after a read, 0 otherwise.
    always @(posedge clk) begin
        logic        issued;
        logic [31:0] exp;
        issued = cs && (wren == 4'h0) && !reset;
        #1;
        if (issued) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underrun", 32'd1, 32'd0);
            end else begin
                exp = sb_q.pop_front();
                check_eq("rd_data", dout, exp);
            end
        end else begin
            check_eq("idle_zero", dout, 32'h0);
        end
    end

    function automatic logic [31:0] m_status();
        int n;
        n = model_q.size();
        return {16'h0000, 8'(n), 3'b000, m_perr, m_unf, m_ovf, 1'(n == DEPTH), 1'(n == 0)};
    endfunction

    // Idle cycle with junk on the address/data lines to prove cs=0 is inert.
    task automatic idle();
        @(negedge clk);
        cs   = 1'b0;
        adr  = 2'($urandom_range(0, 3));
        wren = 4'($urandom_range(0, 15));
        di   = $urandom;
    endtask

    task automatic drive(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
        @(negedge clk);
        cs   = 1'b1;
        adr  = a;
        wren = w;
        di   = d;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        logic [31:0] exp;
        exp = 32'h0;
        case (a)
            2'd0: begin
                if (model_q.size() > 0) exp = model_q.pop_front();
                else m_unf = 1'b1;
            end
            2'd1: exp = m_status();
            2'd2: exp = 32'h0;
            2'd3: if (model_q.size() > 0) exp = model_q[0];
            default: exp = 32'h0;
        endcase
        sb_q.push_back(exp);
        drive(a, 4'h0, 32'h0);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
        if (a == 2'd0) begin
            if (w == 4'hF) begin
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else m_ovf = 1'b1;
            end else begin
                m_perr = 1'b1;
            end
        end else if (a == 2'd2) begin
            if (d[0]) model_q.delete();
            if (d[1]) begin
                m_ovf  = 1'b0;
                m_unf  = 1'b0;
                m_perr = 1'b0;
            end
        end
        drive(a, w, d);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_perr = 1'b0;
    endtask

    // Checks level outputs once the previous access edge has settled.
    task automatic check_level(input string tag);
        idle();
        check_eq({tag, "_count"}, {24'h0, count}, 32'(model_q.size()));
        check_eq({tag, "_not_empty"}, {31'h0, not_empty}, {31'h0, 1'(model_q.size() != 0)});
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1;
        cs    = 1'b0;
        adr   = 2'd0;
        wren  = 4'h0;
        di    = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reset state
        check_level("t1_reset");
        bus_rd(2'd1);
        idle();
        check_eq("t1_status_const", m_status(), 32'h0000_0001);

        // 2: push two, then back-to-back PEEK, DATA, DATA
        bus_wr(2'd0, 4'hF, 32'h1111_1111);
        bus_wr(2'd0, 4'hF, 32'h2222_2222);
        bus_rd(2'd3);
        bus_rd(2'd0);
        bus_rd(2'd0);
        check_level("t2_final");

        // 3: overfill by one, status shows full+ovf, drain in order
        for (int i = 1; i <= DEPTH + 1; i++) bus_wr(2'd0, 4'hF, 32'(i));
        check_level("t3_full");
        check_eq("t3_status_const", m_status(), 32'h0000_1006);
        bus_rd(2'd1);
        bus_rd(2'd2);
        for (int i = 1; i <= DEPTH; i++) bus_rd(2'd0);
        check_level("t3_drained");

        // 4: underflow, then clear sticky flags
        bus_rd(2'd3);
        bus_rd(2'd0);
        bus_rd(2'd1);
        bus_wr(2'd2, 4'hF, 32'h2);
        bus_rd(2'd1);
        idle();

        // 5: partial write is an error, flush discards queued words
        bus_wr(2'd0, 4'b0011, 32'hDEAD_BEEF);
        bus_rd(2'd1);
        bus_wr(2'd1, 4'hF, 32'hFFFF_FFFF);
        bus_wr(2'd3, 4'hF, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) bus_wr(2'd0, 4'hF, 32'hA000_0000 + 32'(i));
        check_level("t5_three");
        bus_wr(2'd2, 4'hF, 32'h1);
        check_level("t5_flush");
        bus_rd(2'd1);
        bus_rd(2'd0);
        bus_wr(2'd2, 4'h1, 32'h3);
        bus_rd(2'd1);

        // 6: reset wins over a same-cycle push with 5 queued
        for (int i = 0; i < 5; i++) bus_wr(2'd0, 4'hF, 32'hB000_0000 + 32'(i));
        check_level("t6_five");
        @(negedge clk);
        reset = 1'b1;
        cs    = 1'b1;
        adr   = 2'd0;
        wren  = 4'hF;
        di    = 32'hCAFE_F00D;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cs    = 1'b0;
        check_eq("t6_count_after_reset", {24'h0, count}, 32'h0);
        check_eq("t6_ne_after_reset", {31'h0, not_empty}, 32'h0);
        bus_rd(2'd1);

        // 40 push/pop pairs walk pointers well past the wrap point
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            bus_wr(2'd0, 4'hF, w);
            if ((i % 7) == 3) bus_rd(2'd3);
            bus_rd(2'd0);
        end
        // Bursty fill/drain around the wrap with the pointers mid-array
        for (int i = 0; i < DEPTH - 2; i++) bus_wr(2'd0, 4'hF, $urandom);
        bus_rd(2'd1);
        for (int i = 0; i < DEPTH - 2; i++) bus_rd(2'd0);
        check_level("t6_end");

        repeat (3) idle();
        check_eq("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
